// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bits.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL_IT = 2'd1,
    ST_DIV_IT = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int unsigned FLAG_DBZ = 0;
  localparam int unsigned FLAG_ILL = 1;
  localparam int unsigned NFLAGS   = 2;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide engine: radix-2 Booth multiply and restoring
// divide sharing one accumulator/shift register pair and iteration counter.
// Divider datapath only present when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               load_i,
`ifdef SEQ_ALU_DIV_EN
  input  logic               div_i,
`endif
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  // acc_q carries one guard bit so Booth can subtract MIN without overflow
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   m_ext, booth_sum;

`ifdef SEQ_ALU_DIV_EN
  logic             div_q, negq_q, negr_q;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo, rem;

  // Divide works on magnitudes; |MIN| still fits as an unsigned WIDTH value
  always_comb begin
    a_abs = a_i[WIDTH-1] ? -a_i : a_i;
    b_abs = b_i[WIDTH-1] ? -b_i : b_i;
  end
`endif

  // One iteration: Booth add/sub + arithmetic shift, or restoring subtract
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({sh_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    sh_d  = {booth_sum[0], sh_q[WIDTH-1:1]};
    qm1_d = sh_q[0];
`ifdef SEQ_ALU_DIV_EN
    rem_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    if (div_q) begin
      qm1_d = 1'b0;
      if (rem_sh >= {1'b0, m_q}) begin
        acc_d = rem_sh - {1'b0, m_q};
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh;
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Load operands on accepted start, then iterate while the FSM steps
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc_q  <= '0;
      sh_q   <= '0;
      m_q    <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
`endif
    end else if (load_i) begin
      acc_q  <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= CW'(WIDTH - 1);
      m_q    <= a_i;
      sh_q   <= b_i;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= div_i;
      negq_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      negr_q <= a_i[WIDTH-1];
      if (div_i) begin
        m_q  <= b_abs;
        sh_q <= a_abs;
      end
`endif
    end else if (step_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      qm1_q <= qm1_d;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last_o = (cnt_q == '0);

  // Final product, or sign-corrected quotient/remainder
  always_comb begin
    res_o = {acc_q[WIDTH-1:0], sh_q};
`ifdef SEQ_ALU_DIV_EN
    quo = negq_q ? -sh_q : sh_q;
    rem = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (div_q) res_o = {rem, quo};
`endif
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU top: start/done handshake FSM, single-cycle operations and
// registered {HI,LO} result with flags. Define SEQ_ALU_DIV_EN to include the
// signed divider; without it DIV decodes as an undefined opcode.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int unsigned    SHW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e              state_q;
  logic                busy_q, done_q;
  logic [2*WIDTH-1:0]  result_q;
  logic [NFLAGS-1:0]   flags_q;
  logic [4:0]          op_q;
  logic [WIDTH-1:0]    a_q, b_q;

  logic                accept, md_step, md_last;
  logic [2*WIDTH-1:0]  md_res;
  logic [SHW-1:0]      shamt;
  logic [SHW:0]        inv_s;
  logic [WIDTH-1:0]    lo1;
  logic                ill1;

  assign accept  = start & ~busy_q;
  assign md_step = (state_q == ST_MUL_IT) || (state_q == ST_DIV_IT);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .clear  (clear),
    .load_i (accept),
`ifdef SEQ_ALU_DIV_EN
    .div_i  (op == OP_DIV),
`endif
    .step_i (md_step),
    .a_i    (a_in),
    .b_i    (b_in),
    .last_o (md_last),
    .res_o  (md_res)
  );

  // Single-cycle operations on the captured operands; unknown opcode flags illegal
  always_comb begin
    shamt = b_q[SHW-1:0];
    inv_s = (SHW+1)'(WIDTH) - {1'b0, shamt};
    lo1   = '0;
    ill1  = 1'b0;
    case (op_q)
      OP_ADD:  lo1 = a_q + b_q;
      OP_SUB:  lo1 = a_q - b_q;
      OP_AND:  lo1 = a_q & b_q;
      OP_OR:   lo1 = a_q | b_q;
      OP_SHR:  lo1 = a_q >> shamt;
      OP_SHRA: lo1 = $signed(a_q) >>> shamt;
      OP_SHL:  lo1 = a_q << shamt;
      // shift by WIDTH yields zero, so s=0 leaves A untouched
      OP_ROR:  lo1 = (a_q >> shamt) | (a_q << inv_s);
      OP_ROL:  lo1 = (a_q << shamt) | (a_q >> inv_s);
      OP_NEG:  lo1 = -a_q;
      OP_NOT:  lo1 = ~a_q;
      default: ill1 = 1'b1;
    endcase
  end

  // Control FSM with registered busy/done/result/flags
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (done_q) begin
            busy_q <= 1'b0;
          end else if (accept) begin
            busy_q  <= 1'b1;
            op_q    <= op;
            a_q     <= a_in;
            b_q     <= b_in;
            flags_q <= '0;
            if (op == OP_MUL) state_q <= ST_MUL_IT;
`ifdef SEQ_ALU_DIV_EN
            else if (op == OP_DIV) state_q <= ST_DIV_IT;
`endif
            else state_q <= ST_FINISH;
          end
        end
        ST_MUL_IT, ST_DIV_IT: begin
          if (md_last) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          state_q  <= ST_IDLE;
          done_q   <= 1'b1;
          result_q <= '0;
          result_q[WIDTH-1:0] <= lo1;
          flags_q[FLAG_ILL]   <= ill1;
          if (op_q == OP_MUL) begin
            result_q          <= md_res;
            flags_q[FLAG_ILL] <= 1'b0;
          end
`ifdef SEQ_ALU_DIV_EN
          else if (op_q == OP_DIV) begin
            flags_q[FLAG_ILL] <= 1'b0;
            if (b_q == '0) begin
              result_q          <= {a_q, ALL_ONES};
              flags_q[FLAG_DBZ] <= 1'b1;
            end else begin
              result_q <= md_res;
            end
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = flags_q[FLAG_DBZ];
  assign illegal_op  = flags_q[FLAG_ILL];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT1 = 2;
  localparam int LATM = W + 2;

  logic           clock = 1'b0;
  logic           clear, start;
  logic [4:0]     op;
  logic [W-1:0]   a_in, b_in;
  logic           busy, done, div_by_zero, illegal_op;
  logic [2*W-1:0] result;

  seq_alu #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        dbz;
    logic        ill;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clock) begin
    if (clear === 1'b0 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, result, mon_e.res);
        chk({mon_e.name, "_dbz"}, 64'(div_by_zero), 64'(mon_e.dbz));
        chk({mon_e.name, "_ill"}, 64'(illegal_op), 64'(mon_e.ill));
        chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc_cyc + 1), 64'(mon_e.lat));
        chk({mon_e.name, "_busy_at_done"}, 64'(busy), 64'(1));
      end
    end
  end

  task automatic issue(input string name, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] r, input logic dbz,
                       input logic ill, input int lat);
    int n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_idle: busy stayed 1, required 0 within 200 cycles", name);
      return;
    end
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clock);
    #1;
    sb.push_back('{name, r, dbz, ill, lat, cyc});
    chk({name, "_flags_clr"}, 64'({div_by_zero, illegal_op}), 64'(0));
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d requests still pending, required 0", name, sb.size());
    end
  endtask

  initial begin
    int base;
    int n;
    clear = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_done",   64'(done), 64'(0));
    chk("rst_result", result, 64'h0);
    chk("rst_dbz",    64'(div_by_zero), 64'(0));
    chk("rst_ill",    64'(illegal_op), 64'(0));
    clear = 1'b0;

    issue("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd1,        64'h0,                   0, 0, LAT1);
    issue("sub",      OP_SUB,  32'd5,        32'd7,        64'h00000000_FFFFFFFE,   0, 0, LAT1);
    issue("and",      OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 64'h00000000_00F000F0,   0, 0, LAT1);
    issue("or",       OP_OR,   32'h12340000, 32'h00005678, 64'h00000000_12345678,   0, 0, LAT1);
    issue("shr",      OP_SHR,  32'h80000000, 32'd4,        64'h00000000_08000000,   0, 0, LAT1);
    issue("shra",     OP_SHRA, 32'h80000000, 32'd4,        64'h00000000_F8000000,   0, 0, LAT1);
    issue("shl31",    OP_SHL,  32'h00000001, 32'd31,       64'h00000000_80000000,   0, 0, LAT1);
    issue("shr_s0",   OP_SHR,  32'hA5A5A5A5, 32'd32,       64'h00000000_A5A5A5A5,   0, 0, LAT1);
    issue("ror8",     OP_ROR,  32'h12345678, 32'd8,        64'h00000000_78123456,   0, 0, LAT1);
    issue("rol4",     OP_ROL,  32'h12345678, 32'd4,        64'h00000000_23456781,   0, 0, LAT1);
    issue("rol_s0",   OP_ROL,  32'h12345678, 32'd0,        64'h00000000_12345678,   0, 0, LAT1);
    issue("neg_min",  OP_NEG,  32'h80000000, 32'd0,        64'h00000000_80000000,   0, 0, LAT1);
    issue("neg_one",  OP_NEG,  32'h00000001, 32'd0,        64'h00000000_FFFFFFFF,   0, 0, LAT1);
    issue("not",      OP_NOT,  32'h0F0F0F0F, 32'd0,        64'h00000000_F0F0F0F0,   0, 0, LAT1);
    issue("ill_1f",   5'b11111, 32'h12345678, 32'd1,       64'h0,                   0, 1, LAT1);
    issue("ill_00",   5'b00000, 32'h12345678, 32'd1,       64'h0,                   0, 1, LAT1);
    issue("mul_m7x6", OP_MUL,  32'hFFFFFFF9, 32'd6,        64'hFFFFFFFF_FFFFFFD6,   0, 0, LATM);
    issue("mul_minsq",OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000,   0, 0, LATM);
    issue("mul_maxsq",OP_MUL,  32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001,   0, 0, LATM);
    issue("mul_m1m1", OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001,   0, 0, LATM);
`ifdef SEQ_ALU_DIV_EN
    issue("div_m7_2", OP_DIV,  32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD,   0, 0, LATM);
    issue("div_5_0",  OP_DIV,  32'd5,        32'd0,        64'h00000005_FFFFFFFF,   1, 0, LATM);
    issue("add_aft",  OP_ADD,  32'd2,        32'd3,        64'h00000000_00000005,   0, 0, LAT1);
    issue("div_min_m1",OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000,   0, 0, LATM);
    issue("div_100_7",OP_DIV,  32'd100,      32'd7,        64'h00000002_0000000E,   0, 0, LATM);
    issue("div_7_m2", OP_DIV,  32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD,   0, 0, LATM);
    issue("div_m8_m3",OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002,   0, 0, LATM);
`else
    issue("div_off",  OP_DIV,  32'hFFFFFFF9, 32'd2,        64'h0,                   0, 1, LAT1);
    issue("div0_off", OP_DIV,  32'd5,        32'd0,        64'h0,                   0, 1, LAT1);
    issue("add_aft",  OP_ADD,  32'd2,        32'd3,        64'h00000000_00000005,   0, 0, LAT1);
`endif

    // start held high for the whole MUL: only one done, next op taken after it
    drain("pre_flood");
    issue("flood_mul", OP_MUL, 32'd3, 32'd5, 64'h00000000_0000000F, 0, 0, LATM);
    base = done_cnt;
    op = OP_ADD; a_in = 32'd1; b_in = 32'd1; start = 1'b1;
    n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL flood_wait_idle: busy stayed 1, required 0 within 100 cycles");
    end
    chk("flood_one_done", 64'(done_cnt - base), 64'(1));
    @(posedge clock);
    #1;
    sb.push_back('{"flood_add", 64'h00000000_00000002, 1'b0, 1'b0, LAT1, cyc});
    start = 1'b0;

    // asynchronous clear during MUL iteration 10
    drain("pre_rstmid");
    @(negedge clock);
    op = OP_MUL; a_in = 32'd1000; b_in = 32'd1000; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("rstmid_busy_before", 64'(busy), 64'(1));
    clear = 1'b1;
    #1;
    chk("rstmid_busy",   64'(busy), 64'(0));
    chk("rstmid_done",   64'(done), 64'(0));
    chk("rstmid_result", result, 64'h0);
    chk("rstmid_flags",  64'({div_by_zero, illegal_op}), 64'(0));
    @(negedge clock);
    clear = 1'b0;
    base = done_cnt;
    repeat (40) @(negedge clock);
    chk("rstmid_no_done", 64'(done_cnt - base), 64'(0));
    chk("rstmid_idle",    64'(busy), 64'(0));
    issue("add_recover", OP_ADD, 32'd7, 32'd8, 64'h00000000_0000000F, 0, 0, LAT1);

    drain("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
